// File: rtl/fetch_unit.sv
// Front-end fetch/staging: instruction capture, PC, result register and N×N matrix staging buffer.
// Optional FETCH_DONE_CLR_EN: DONE rising edge clears the whole staged matrix.

module fetch_mat_row #(
  parameter int N = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                clr,
  input  logic                ld,
  input  logic [N-1:0][31:0]  din,
  output logic [N-1:0][31:0]  row
);
  always_ff @(posedge CLK) begin
    if (RSTN || clr) row <= '0;
    else if (ld)     row <= din;
  end
endmodule

module fetch_unit #(
  parameter int          N    = 2,
  parameter logic [31:0] ADDR = 32'h00000000,
  parameter int          REGN = 512,
  localparam int         PCW  = $clog2(REGN/2),
  localparam int         SW   = $clog2(N)
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic [31:0]                INSTRDATA,
  input  logic [N-1:0][31:0]         MAT_IN,
  input  logic                       MATAB_MUX,
  input  logic [SW-1:0]              SEQ_B,
  input  logic                       DONE,
  input  logic                       DOUT_MUX,
  input  logic [31:0]                DATAOUT,
  output logic [PCW-1:0]             PC_INS,
  output logic [31:0]                INSTR,
  output logic [31:0]                RESULT,
  output logic [N-1:0][N-1:0][31:0]  MAT_OUT
);
  logic done_q;
  logic done_rise;
  logic mat_clr;

  assign done_rise = DONE && !done_q;

`ifdef FETCH_DONE_CLR_EN
  assign mat_clr = done_rise;
`else
  assign mat_clr = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      done_q <= 1'b0;
      PC_INS <= ADDR[PCW-1:0];
      INSTR  <= '0;
      RESULT <= '0;
    end else begin
      done_q <= DONE;
      if (!DONE)     INSTR  <= INSTRDATA;
      if (done_rise) PC_INS <= PC_INS + 1'b1;
      if (DOUT_MUX)  RESULT <= DATAOUT;
    end
  end

  // Row 0 always takes MAT_IN; higher rows take the row below when shifting A.
  for (genvar r = 0; r < N; r++) begin : g_row
    logic               ld;
    logic [N-1:0][31:0] din;
    if (r == 0) begin : g_first
      assign din = MAT_IN;
    end else begin : g_rest
      assign din = MATAB_MUX ? MAT_OUT[r-1] : MAT_IN;
    end
    assign ld = MATAB_MUX || (SEQ_B == SW'(r));
    fetch_mat_row #(.N(N)) u_row (
      .CLK (CLK),
      .RSTN(RSTN),
      .clr (mat_clr),
      .ld  (ld),
      .din (din),
      .row (MAT_OUT[r])
    );
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then random traffic against a behavioural model.
module tb_fetch_unit;
  localparam int N   = 2;
  localparam int PCW = 8;

  logic                      CLK = 1'b0;
  logic                      RSTN;
  logic [31:0]               INSTRDATA;
  logic [N-1:0][31:0]        MAT_IN;
  logic                      MATAB_MUX;
  logic [0:0]                SEQ_B;
  logic                      DONE;
  logic                      DOUT_MUX;
  logic [31:0]               DATAOUT;
  logic [PCW-1:0]            PC_INS;
  logic [31:0]               INSTR;
  logic [31:0]               RESULT;
  logic [N-1:0][N-1:0][31:0] MAT_OUT;

  fetch_unit #(.N(N), .ADDR(32'h0), .REGN(512)) dut (
    .CLK(CLK), .RSTN(RSTN), .INSTRDATA(INSTRDATA), .MAT_IN(MAT_IN),
    .MATAB_MUX(MATAB_MUX), .SEQ_B(SEQ_B), .DONE(DONE), .DOUT_MUX(DOUT_MUX),
    .DATAOUT(DATAOUT), .PC_INS(PC_INS), .INSTR(INSTR), .RESULT(RESULT),
    .MAT_OUT(MAT_OUT)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int unsigned m_pc;
  logic [31:0] m_instr, m_res;
  logic [31:0] m_mat [N][N];
  bit          m_dq;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] nxt [N][N];
    if (RSTN) begin
      m_pc = 0; m_instr = 0; m_res = 0; m_dq = 0;
      foreach (m_mat[r, c]) m_mat[r][c] = 0;
      return;
    end
    if (!DONE) m_instr = INSTRDATA;
    if (DOUT_MUX) m_res = DATAOUT;
    nxt = m_mat;
    if (!MATAB_MUX) begin
      for (int c = 0; c < N; c++) nxt[SEQ_B][c] = MAT_IN[c];
    end else begin
      for (int r = N - 1; r > 0; r--) nxt[r] = m_mat[r-1];
      for (int c = 0; c < N; c++) nxt[0][c] = MAT_IN[c];
    end
    if (DONE && !m_dq) begin
      m_pc = (m_pc + 1) % (1 << PCW);
`ifdef FETCH_DONE_CLR_EN
      foreach (nxt[r, c]) nxt[r][c] = 0;
`endif
    end
    m_mat = nxt;
    m_dq = DONE;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(PC_INS), 32'(m_pc));
    chk({tag, ".instr"}, INSTR, m_instr);
    chk({tag, ".result"}, RESULT, m_res);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk($sformatf("%s.mat[%0d][%0d]", tag, r, c), MAT_OUT[r][c], m_mat[r][c]);
  endtask

  task automatic step(input string tag, input logic rst, input logic done, input logic dmux,
                      input logic abmux, input logic seq, input logic [31:0] ins,
                      input logic [31:0] dout, input logic [31:0] m1, input logic [31:0] m0);
    RSTN = rst; DONE = done; DOUT_MUX = dmux; MATAB_MUX = abmux; SEQ_B = seq;
    INSTRDATA = ins; DATAOUT = dout; MAT_IN[1] = m1; MAT_IN[0] = m0;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    #2;
    // Reset with garbage inputs
    step("reset", 1, 1, 1, 1, 1, 32'hdeadbeef, 32'hcafef00d, 32'h1111, 32'h2222);
    chk("reset.pc0", 32'(PC_INS), 32'h0);
    // B indexed load of row 1
    step("bload", 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'd2, 32'd1);
    chk("bload.row1", MAT_OUT[1][1], 32'd2);
    // A shift-in
    step("ashift1", 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'd4, 32'd5);
    step("ashift2", 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'd7, 32'd8);
    chk("ashift.row1", MAT_OUT[1][0], 32'd5);
    // Instruction fetch; park matrix by reloading row 0 with same content
    step("fetch1", 0, 0, 0, 0, 0, 32'd5, 32'h0, 32'd7, 32'd8);
    step("fetch2", 0, 0, 0, 0, 0, 32'd5, 32'h0, 32'd7, 32'd8);
    chk("fetch.instr", INSTR, 32'd5);
    // Completion held two cycles
    step("done1", 0, 1, 1, 0, 0, 32'd9, 32'd45, 32'd7, 32'd8);
    chk("done1.pc", 32'(PC_INS), 32'd1);
    chk("done1.result", RESULT, 32'd45);
    step("done2", 0, 1, 1, 0, 0, 32'd9, 32'd45, 32'd7, 32'd8);
    chk("done2.pc", 32'(PC_INS), 32'd1);
    chk("done2.instr", INSTR, 32'd5);
    // Walk PC up to 255 with single-cycle DONE pulses
    while (m_pc != 255) begin
      step("walk0", 0, 0, 0, 1, 0, $urandom, $urandom, $urandom, $urandom);
      step("walk1", 0, 1, 0, 1, 0, $urandom, $urandom, $urandom, $urandom);
    end
    chk("walk.pc255", 32'(PC_INS), 32'd255);
    step("wrap0", 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    step("wrap1", 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("wrap.pc0", 32'(PC_INS), 32'd0);
    // Bring PC to 3, fill matrix, then reset mid-shift
    for (int i = 0; i < 3; i++) begin
      step("pc3a", 0, 0, 1, 1, 0, 32'h0, 32'h77, 32'h0, 32'h0);
      step("pc3b", 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
    step("fill1", 0, 0, 0, 1, 0, 32'h3, 32'h0, 32'haa, 32'hbb);
    step("fill2", 0, 0, 0, 1, 0, 32'h3, 32'h0, 32'hcc, 32'hdd);
    chk("fill.pc3", 32'(PC_INS), 32'd3);
    step("midrst", 1, 0, 1, 1, 0, 32'h3, 32'h99, 32'hee, 32'hff);
    chk("midrst.row0", MAT_OUT[0][0], 32'd0);
    // DONE pulse after B load (clears matrix only with the optional feature)
    step("clrb", 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h12, 32'h34);
    step("clrd", 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h56, 32'h78);
`ifdef FETCH_DONE_CLR_EN
    chk("clr.row1", MAT_OUT[1][0], 32'd0);
`else
    chk("clr.row1", MAT_OUT[1][0], 32'h34);
`endif
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch/staging block of the SIMD matrix processor.
- Captures instruction words and drives the instruction program counter.
- Stages matrix B rows (indexed writes) and matrix A rows (shift-in) into an N×N word buffer for the compute array.
- Registers the compute result for output when the datapath signals completion.

Parameters:
- N, 2, matrix dimension (rows/columns per matrix and words per MAT_IN row); power of two, ≥2.
- ADDR, 32'h00000000, reset/start value of the program counter (truncated to PC width).
- REGN, 512, total register-file words; PC width = clog2(REGN/2).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RSTN  in  1  synchronous, active-high reset (name kept per codebase convention despite polarity).
- INSTRDATA  in  32  instruction word from instruction memory.
- MAT_IN  in  N×32 (packed [N-1:0][31:0])  one matrix row; element i = column i.
- MATAB_MUX  in  1  0 = matrix B indexed row load, 1 = matrix A shift-in load.
- SEQ_B  in  clog2(N)  target row index for matrix B load.
- DONE  in  1  current instruction complete; freezes INSTR and advances PC.
- DOUT_MUX  in  1  1 = capture DATAOUT into RESULT.
- DATAOUT  in  32  result word from the compute datapath.
- PC_INS  out  clog2(REGN/2)  instruction address.
- INSTR  out  32  registered current instruction.
- RESULT  out  32  registered result word.
- MAT_OUT  out  N×N×32 (packed [N-1:0][N-1:0][31:0])  staged matrix; [r][c] = row r, column c.

Behaviour:
- Reset (RSTN=1 at rising edge):
  - PC_INS = ADDR[W-1:0].
  - INSTR = 0.
  - RESULT = 0.
  - all MAT_OUT words = 0.
  - Reset overrides every other input. Mid-operation reset discards staged data; outputs take reset values one edge later.
- All outputs are registers; latency 1 cycle from input to output. No combinational input-to-output paths.
- Instruction capture:
  - DONE=0: INSTR <= INSTRDATA every cycle.
  - DONE=1: INSTR holds.
- PC:
  - Internal done_q register (reset 0) tracks the previous DONE.
  - PC_INS <= PC_INS+1 only on the cycle DONE=1 and done_q=0. DONE held high for multiple cycles advances PC exactly once.
  - PC wraps modulo 2^W (all-ones → 0).
- Result:
  - DOUT_MUX=1: RESULT <= DATAOUT.
  - DOUT_MUX=0: RESULT holds.
  - Independent of DONE.
- Matrix staging (every non-reset cycle):
  - MATAB_MUX=0: MAT_OUT[SEQ_B] <= MAT_IN. Other rows hold.
  - MATAB_MUX=1: shift-in.
    - MAT_OUT[0] <= MAT_IN.
    - MAT_OUT[r] <= MAT_OUT[r-1] for r=1..N-1.
    - The oldest row falls out.
  - No separate load enable. The controller parks MATAB_MUX/MAT_IN appropriately; whatever is present is captured.
- DONE, DOUT_MUX and matrix staging may all be active in the same cycle. Each acts on its own registers with no priority interaction.
- INSTRDATA/MAT_IN/DATAOUT may be undriven when not being loaded. Undriven values are captured as-is; the block does no X/Z filtering.

Optional Feature:
- Macro FETCH_DONE_CLR_EN.
- Defined: on the DONE rising-edge cycle (DONE=1, done_q=0), all MAT_OUT words are cleared to 0. This clear takes priority over that cycle's matrix staging write.
- Undefined: MAT_OUT is unaffected by DONE.

Test Plan:
- Reset: RSTN=1 for one edge with garbage inputs → PC_INS=0, INSTR=0, RESULT=0, all MAT_OUT=0. Then RSTN=0.
- B load (N=2): MATAB_MUX=0, SEQ_B=1, MAT_IN={2,1} (elem1=2, elem0=1) → after one edge, MAT_OUT[1]={2,1} and MAT_OUT[0]={0,0}.
- A shift: MATAB_MUX=1, MAT_IN={4,5} for one edge, then {7,8} for one edge → MAT_OUT[0]={7,8}, MAT_OUT[1]={4,5}.
- Instruction fetch: INSTRDATA=5, DONE=0 for 2 edges → INSTR=5, PC_INS stays 0.
- Completion: DONE=1, DOUT_MUX=1, DATAOUT=45 held 2 edges → RESULT=45 after first edge; PC_INS 0→1 once (still 1 after second edge); INSTR holds 5. Then PC preloaded to 255 via repeated DONE pulses; one more pulse → PC_INS=0 (wrap).
- Mid-op reset: during A shift with MAT_OUT non-zero and PC=3, assert RSTN one edge → all outputs return to reset values. With FETCH_DONE_CLR_EN: a DONE pulse after B load → MAT_OUT all 0.
